tdes_round_seq: RTL and testbench

TDES_ROUND_SEQ -- requirements
Module: tdes_round_seq

---
 rtl/tdes_round_seq.sv | 148 ++++++++++++++
 tb/tb_tdes_round_seq.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdes_round_seq.sv
// tdes_round_seq -- control sequencer for an iterative triple-DES datapath.
// Walks one 64-bit block through LOAD, three DES passes of KEY + 16 ROUND
// cycles, a FINAL permutation cycle and a DONE hold until the result is
// acknowledged. All outputs are Moore decodes of state and counters.
// Optional feature: define TDES_KEYOPT2_EN to add i_keyopt2 (K3=K1 keying).
module tdes_round_seq (
  input  logic       i_clk,
  input  logic       i_n_rst,
  input  logic       i_start,
  input  logic       i_encrypt,
  input  logic       i_abort,
  input  logic       i_out_ack,
`ifdef TDES_KEYOPT2_EN
  input  logic       i_keyopt2,
`endif
  output logic       o_load_block,
  output logic       o_key_load,
  output logic [1:0] o_key_sel,
  output logic       o_round_en,
  output logic [3:0] o_subkey_idx,
  output logic [1:0] o_stage,
  output logic       o_fp_en,
  output logic       o_busy,
  output logic       o_out_valid
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_KEY   = 3'd2,
    S_ROUND = 3'd3,
    S_FINAL = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_stage;
  logic [3:0] r_round;
  logic       r_enc;
  logic       w_kopt2;
  logic       w_last_round;
  logic       w_pass_e;
  logic [1:0] w_key_base;

`ifdef TDES_KEYOPT2_EN
  logic       r_kopt2;

  // Keying option is captured alongside the direction when a block is accepted.
  always_ff @(posedge i_clk) begin
    if (!i_n_rst)
      r_kopt2 <= 1'b0;
    else if (r_state == S_IDLE && i_start)
      r_kopt2 <= i_keyopt2;
  end

  assign w_kopt2 = r_kopt2;
`else
  assign w_kopt2 = 1'b0;
`endif

  assign w_last_round = (r_round == 4'd15);

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_n_rst)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  // Pass/round counters and captured direction; frozen outside ROUND so an
  // aborted or finished block leaves no effect once IDLE masks them.
  always_ff @(posedge i_clk) begin
    if (!i_n_rst) begin
      r_stage <= 2'd0;
      r_round <= 4'd0;
      r_enc   <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (i_start) begin
        r_stage <= 2'd0;
        r_round <= 4'd0;
        r_enc   <= i_encrypt;
      end
    end else if (r_state == S_ROUND && !i_abort) begin
      if (w_last_round) begin
        r_round <= 4'd0;
        if (r_stage != 2'd2)
          r_stage <= r_stage + 2'd1;
      end else begin
        r_round <= r_round + 4'd1;
      end
    end
  end

  // Next-state logic; abort out-ranks every other transition when busy.
  always_comb begin
    w_next = r_state;
    if (r_state != S_IDLE && i_abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (i_start) w_next = S_LOAD;
        S_LOAD:  w_next = S_KEY;
        S_KEY:   w_next = S_ROUND;
        S_ROUND: if (w_last_round) w_next = (r_stage == 2'd2) ? S_FINAL : S_KEY;
        S_FINAL: w_next = S_DONE;
        S_DONE:  if (i_out_ack) w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Pass 1 always runs opposite to passes 0 and 2 (E-D-E / D-E-D).
  assign w_pass_e   = r_enc ^ (r_stage == 2'd1);
  // Encrypt walks K1,K2,K3; decrypt walks K3,K2,K1. r_stage never reaches 3.
  assign w_key_base = r_enc ? r_stage : (2'd2 - r_stage);

  // Moore output decode; everything is zero in IDLE.
  always_comb begin
    o_load_block = 1'b0;
    o_key_load   = 1'b0;
    o_key_sel    = 2'd0;
    o_round_en   = 1'b0;
    o_subkey_idx = 4'd0;
    o_stage      = 2'd0;
    o_fp_en      = 1'b0;
    o_busy       = 1'b0;
    o_out_valid  = 1'b0;
    if (r_state != S_IDLE) begin
      o_busy    = 1'b1;
      o_stage   = r_stage;
      o_key_sel = (w_kopt2 && w_key_base == 2'd2) ? 2'd0 : w_key_base;
    end
    case (r_state)
      S_LOAD:  o_load_block = 1'b1;
      S_KEY:   o_key_load   = 1'b1;
      S_ROUND: begin
        o_round_en   = 1'b1;
        o_subkey_idx = w_pass_e ? r_round : (4'd15 - r_round);
      end
      S_FINAL: o_fp_en      = 1'b1;
      S_DONE:  o_out_valid  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tdes_round_seq.sv
// Bench for tdes_round_seq: an offset-from-start timing model predicts the
// full output bundle every cycle; directed runs pin the model with literals,
// then a randomized phase stresses start/abort/ack/reset interleavings.
module tb_tdes_round_seq;

  logic       clk = 1'b0;
  logic       n_rst, start, encrypt, abort_i, out_ack, keyopt2;
  logic       o_load_block, o_key_load, o_round_en, o_fp_en, o_busy, o_out_valid;
  logic [1:0] o_key_sel, o_stage;
  logic [3:0] o_subkey_idx;

  always #5 clk = ~clk;

  tdes_round_seq dut (
    .i_clk       (clk),
    .i_n_rst     (n_rst),
    .i_start     (start),
    .i_encrypt   (encrypt),
    .i_abort     (abort_i),
    .i_out_ack   (out_ack),
`ifdef TDES_KEYOPT2_EN
    .i_keyopt2   (keyopt2),
`endif
    .o_load_block(o_load_block),
    .o_key_load  (o_key_load),
    .o_key_sel   (o_key_sel),
    .o_round_en  (o_round_en),
    .o_subkey_idx(o_subkey_idx),
    .o_stage     (o_stage),
    .o_fp_en     (o_fp_en),
    .o_busy      (o_busy),
    .o_out_valid (o_out_valid)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Model: an operation is just "active since cycle t0"; outputs follow from
  // k = cycle - t0 (load@1, 3 x (key + 16 rounds) from 2, final@53, done>=54).
  bit m_act  = 1'b0;
  int m_t0   = 0;
  bit m_enc  = 1'b0;
  bit m_kopt = 1'b0;
  int mk;

  always @(posedge clk) begin
    mk = cyc - m_t0;
    if (!n_rst) begin
      m_act = 1'b0;
    end else if (!m_act) begin
      if (start) begin
        m_act = 1'b1;
        m_t0  = cyc;
        m_enc = encrypt;
`ifdef TDES_KEYOPT2_EN
        m_kopt = keyopt2;
`else
        m_kopt = 1'b0;
`endif
      end
    end else if (abort_i) begin
      m_act = 1'b0;
    end else if (mk >= 54 && out_ack) begin
      m_act = 1'b0;
    end
    cyc++;
  end

  // {load, key_load, key_sel[2], round_en, subkey[4], stage[2], fp, busy, out_valid}
  function automatic logic [13:0] exp_vec(bit act, int k, bit enc, bit kopt);
    logic       ld, kl, re, fp, ov;
    logic [1:0] ks, st;
    logic [3:0] sk;
    int         s, r;
    bit         e;
    ld = 0; kl = 0; re = 0; fp = 0; ov = 0; sk = 0;
    if (!act) return 14'd0;
    s  = (k < 2) ? 0 : (k >= 53) ? 2 : (k - 2) / 17;
    ks = enc ? 2'(s) : 2'(2 - s);
    if (kopt && ks == 2'd2) ks = 2'd0;
    st = 2'(s);
    if (k == 1) ld = 1;
    else if (k <= 52) begin
      r = (k - 2) % 17;
      if (r == 0) kl = 1;
      else begin
        re = 1;
        e  = enc ^ (s == 1);
        sk = e ? 4'(r - 1) : 4'(16 - r);
      end
    end else if (k == 53) fp = 1;
    else ov = 1;
    return {ld, kl, ks, re, sk, st, fp, 1'b1, ov};
  endfunction

  // Per-cycle comparison of the whole output bundle against the model.
  always @(negedge clk) begin
    logic [13:0] got, exp;
    got = {o_load_block, o_key_load, o_key_sel, o_round_en, o_subkey_idx,
           o_stage, o_fp_en, o_busy, o_out_valid};
    exp = exp_vec(m_act, cyc - m_t0, m_enc, m_kopt);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL bundle cyc=%0d k=%0d got=%b exp=%b", cyc, cyc - m_t0, got, exp);
    end
    n_chk++;
    if (int'(o_load_block) + int'(o_key_load) + int'(o_round_en) + int'(o_fp_en) > 1) begin
      n_fail++;
      $display("FAIL onehot cyc=%0d ld=%b kl=%b re=%b fp=%b", cyc,
               o_load_block, o_key_load, o_round_en, o_fp_en);
    end
  end

  task automatic chk(string nm, int got, int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  // Wait (bounded) for out_valid, then acknowledge it for one cycle.
  task automatic finish_op();
    int n;
    n = 0;
    while (!o_out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    n_chk++;
    if (!o_out_valid) begin
      n_fail++;
      $display("FAIL done_timeout got=0 exp=1 after %0d cycles", n);
    end
    out_ack = 1'b1;
    @(negedge clk);
    out_ack = 1'b0;
  endtask

  initial begin
    n_rst = 0; start = 1; encrypt = 1; abort_i = 0; out_ack = 1; keyopt2 = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_load", int'(o_load_block), 0);
    chk("rst_ov",   int'(o_out_valid), 0);
    n_rst = 1; start = 0; out_ack = 0;
    @(negedge clk);

    // Encrypt run with literal timing and index checks.
    start = 1; encrypt = 1;
    @(negedge clk);
    start = 0;
    chk("e_load@1", int'(o_load_block), 1);
    for (int k = 2; k <= 54; k++) begin
      @(negedge clk);
      if (k == 2)  chk("e_ksel@2",  int'(o_key_sel), 0);
      if (k == 19) chk("e_ksel@19", int'(o_key_sel), 1);
      if (k == 36) chk("e_ksel@36", int'(o_key_sel), 2);
      if (k == 3)  chk("e_sk@3",    int'(o_subkey_idx), 0);
      if (k == 18) chk("e_sk@18",   int'(o_subkey_idx), 15);
      if (k == 20) chk("e_sk@20",   int'(o_subkey_idx), 15);
      if (k == 35) chk("e_sk@35",   int'(o_subkey_idx), 0);
      if (k == 52) chk("e_sk@52",   int'(o_subkey_idx), 15);
      if (k == 53) chk("e_fp@53",   int'(o_fp_en), 1);
      if (k == 54) chk("e_ov@54",   int'(o_out_valid), 1);
    end
    out_ack = 1;
    @(negedge clk);
    out_ack = 0;
    chk("e_idle", int'(o_busy), 0);

    // Decrypt run, start held high throughout, ack noise while not DONE.
    start = 1; encrypt = 0;
    @(negedge clk);
    encrypt = 1'($urandom);
    for (int k = 2; k <= 54; k++) begin
      @(negedge clk);
      out_ack = (k < 54) ? 1'($urandom) : 1'b0;
      if (k == 2)  chk("d_ksel@2",  int'(o_key_sel), 2);
      if (k == 19) chk("d_ksel@19", int'(o_key_sel), 1);
      if (k == 36) chk("d_ksel@36", int'(o_key_sel), 0);
      if (k == 3)  chk("d_sk@3",    int'(o_subkey_idx), 15);
      if (k == 20) chk("d_sk@20",   int'(o_subkey_idx), 0);
      if (k == 37) chk("d_sk@37",   int'(o_subkey_idx), 15);
      if (k == 53) chk("d_fp@53",   int'(o_fp_en), 1);
    end
    for (int i = 0; i < 10; i++) begin
      chk("hold_ov", int'(o_out_valid), 1);
      if (i < 9) @(negedge clk);
    end
    out_ack = 1;
    @(negedge clk);
    out_ack = 0;
    chk("b2b_idle", int'(o_busy), 0);
    @(negedge clk);
    chk("b2b_load", int'(o_load_block), 1);
    start = 0;
    finish_op();

    // Abort at stage 1, round 7, then a clean block.
    start = 1; encrypt = 1;
    @(negedge clk);
    start = 0;
    repeat (26) @(negedge clk);
    chk("ab_stage", int'(o_stage), 1);
    chk("ab_sk",    int'(o_subkey_idx), 8);
    abort_i = 1; out_ack = 1;
    @(negedge clk);
    abort_i = 0; out_ack = 0;
    chk("ab_busy", int'(o_busy), 0);
    repeat (60) @(negedge clk);
    start = 1; encrypt = 0;
    @(negedge clk);
    start = 0;
    finish_op();

    // Reset during stage-2 KEY with start held high; no resume afterwards.
    start = 1; encrypt = 1;
    @(negedge clk);
    repeat (35) @(negedge clk);
    chk("rk_keyload", int'(o_key_load), 1);
    chk("rk_stage",   int'(o_stage), 2);
    n_rst = 0;
    @(negedge clk);
    chk("rk_busy", int'(o_busy), 0);
    chk("rk_ksel", int'(o_key_sel), 0);
    n_rst = 1; start = 0;
    repeat (60) @(negedge clk);
    chk("rk_noresume", int'(o_busy), 0);

`ifdef TDES_KEYOPT2_EN
    start = 1; encrypt = 1; keyopt2 = 1;
    @(negedge clk);
    start = 0; keyopt2 = 0;
    for (int k = 2; k <= 36; k++) begin
      @(negedge clk);
      if (k == 19) chk("k2_ksel@19", int'(o_key_sel), 1);
      if (k == 36) chk("k2_ksel@36", int'(o_key_sel), 0);
    end
    finish_op();
`endif

    // Randomized interleaving of all inputs; the bundle model checks each cycle.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      start   = ($urandom % 4) == 0;
      encrypt = 1'($urandom);
      keyopt2 = 1'($urandom);
      out_ack = ($urandom % 3) == 0;
      abort_i = ($urandom % 150) == 0;
      n_rst   = ($urandom % 700) != 0;
    end
    n_rst = 1; start = 0; abort_i = 0; out_ack = 0;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
